// File: rtl/fir_out_requant_if.sv
// Stream bundle for the FIR output requantizer.
// Sample input, head-of-FIFO output and status.
interface fir_out_requant_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                    in_valid;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic [LW-1:0]           fifo_level;
  logic                    overflow;
  logic [CNT_W-1:0]        sat_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, fifo_level,
    input  overflow, sat_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, fifo_level,
    output overflow, sat_count
  );
endinterface

// File: rtl/fir_out_requant.sv
// FIR output requantizer: rounding shift, clip to
// OUT_W, small FIFO towards a valid/ready consumer.
module fir_out_requant #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int SHIFT = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  fir_out_requant_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef logic signed [IN_W:0] wide_t;

  localparam wide_t RND = wide_t'((2 ** SHIFT) / 2);
  localparam wide_t HI  = wide_t'((2 ** (OUT_W - 1)) - 1);
  localparam wide_t LO  = wide_t'(-(2 ** (OUT_W - 1)));

  typedef struct packed {
    logic                    vld;
    logic                    clip;
    logic signed [OUT_W-1:0] q;
  } s1_t;

  wide_t                   t;
  wide_t                   r;
  logic                    hi;
  logic                    lo;
  logic signed [OUT_W-1:0] q;
  s1_t                     s1;

  always_comb begin
    t  = {bus.in_data[IN_W-1], bus.in_data};
    t  = t + RND;
    r  = t >>> SHIFT;
    hi = r > HI;
    lo = r < LO;
    q  = r[OUT_W-1:0];
    unique case (1'b1)
      hi:      q = HI[OUT_W-1:0];
      lo:      q = LO[OUT_W-1:0];
      default: q = r[OUT_W-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
    end else begin
      s1.vld  <= bus.in_valid;
      s1.clip <= hi | lo;
      s1.q    <= q;
    end
  end

  logic signed [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [LW-1:0]           cnt;
  logic                    ovf;
  logic [CNT_W-1:0]        sat;
  logic                    pop;
  logic                    full;
  logic                    push;
  logic                    drop;

  // A pop in the same cycle frees the slot a full FIFO needs.
  assign pop  = (cnt != '0) && bus.out_ready;
  assign full = cnt == LW'(DEPTH);
  assign push = s1.vld && (!full || pop);
  assign drop = s1.vld && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s1.q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      sat    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        push && !pop: cnt <= cnt + 1'b1;
        pop && !push: cnt <= cnt - 1'b1;
        default:      cnt <= cnt;
      endcase
      if (drop) ovf <= 1'b1;
      if (s1.vld && s1.clip && sat != '1)
        sat <= sat + 1'b1;
    end
  end

  assign bus.out_valid  = cnt != '0;
  assign bus.out_data   = bus.out_valid ? mem[rd_ptr] : '0;
  assign bus.fifo_level = cnt;
  assign bus.overflow   = ovf;
  assign bus.sat_count  = sat;
endmodule

// File: doc/fir_out_requant.md
# fir_out_requant

Output-side reader for the FIR datapath. It accepts the 16-bit signed filter result stream and removes the filter's DC gain with a rounding arithmetic right shift. It saturates the result back to the 8-bit sample width and buffers the samples in a small FIFO. Downstream consumers read the samples over a valid/ready handshake. The block sits directly after the FIR filter and returns samples to the 8-bit domain the filter consumed.

## Interface
- IN_W, 16, input sample width (signed)
- OUT_W, 8, output sample width (signed); must be < IN_W
- SHIFT, 2, right-shift amount (gain removal; 2 matches coefficient sum 4); 0 ≤ SHIFT < IN_W
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- CNT_W, 16, saturation counter width
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high; sampled on rising clk edge only
- in_valid  input  1  in_data is a new sample this cycle; no upstream backpressure
- in_data  input  IN_W  signed filter output
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  OUT_W  signed requantized sample at FIFO head
- fifo_level  output  log2(DEPTH)+1  current occupancy
- overflow  output  1  sticky: a sample was dropped because the FIFO was full
- sat_count  output  CNT_W  number of samples clipped; saturates at all-ones

## Operation
- Stage 1 (registered), per in_valid sample:
  - Form t = sext(in_data, IN_W+1) + (SHIFT>0 ? 2^(SHIFT-1) : 0).
  - Arithmetic shift: r = t >>> SHIFT. Rounding is half-up toward +inf, e.g. -1.5 → -1 and +1.5 → +2.
  - Clip r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Set the stage-1 clip flag when clipping occurs.
- Stage 2 is the FIFO write of the stage-1 result. The FIFO is a circular buffer with rd/wr pointers and an occupancy count.
- Push rule: write is accepted if fifo_level < DEPTH, or if a pop occurs in the same cycle. Otherwise the sample is discarded and overflow is set to 1.
- Pop rule: pop occurs when out_valid && out_ready. out_data is the head entry, driven from the memory read of rd pointer.
- Simultaneous push and pop: fifo_level is unchanged and both pointers advance.
- sat_count increments by 1 for every stage-1 sample with the clip flag set, whether or not the sample is later dropped. It holds at 2^CNT_W-1.
- overflow stays at 1 until reset; nothing else clears it.
- Pointers wrap modulo DEPTH.
- Stage-1 valid is a registered copy of in_valid. Gaps in in_valid produce no writes.

## Timing
- Reset values: out_valid=0, out_data=0, fifo_level=0, overflow=0, sat_count=0. Stage-1 valid is cleared, and pointers are cleared to 0.
- Latency:
  - in_valid sampled at edge E → stage-1 register loaded at E.
  - FIFO written at E+1.
  - out_valid=1 and out_data valid in the cycle after E+1 (2 cycles in→out when empty).
- Throughput: 1 sample/cycle sustained when out_ready is held at 1.
- out_data and out_valid depend only on registers; there is no combinational path from in_* or out_ready.
- Reset mid-operation: the stage-1 sample in flight and all FIFO contents are discarded. All outputs take their reset values on the reset edge.

## Test plan
- Rounding: feed in_data = 6, -6, 5, -5, 0, with out_ready=1. Expected out_data sequence is 2, -1, 1, -1, 0. Expect sat_count=0, first out_valid 2 cycles after the first in_valid, and no bubbles.
- Saturation: feed in_data = 32767 (0x7FFF) and -32768 (0x8000). Expected out_data is 127 and -128, with sat_count=2. Then feed 508 → 127 (unclipped, sat_count stays 2), then 510 → 127 with sat_count=3.
- Full/overflow: hold out_ready=0 and feed 5 consecutive samples 4, 8, 12, 16, 20. Expect fifo_level=4 and overflow=1. Then raise out_ready; expect reads of 1, 2, 3, 4, then out_valid=0.
- Push+pop at full: fill to 4 with out_ready=0, then assert out_ready=1 and in_valid=1 in the same cycle. Expect no drop, overflow to remain 0, fifo_level to stay 4, and order preserved.
- Reset mid-stream: while fifo_level=3 with a sample in stage 1, assert reset for 1 cycle. Expect all outputs zero on the next cycle, and the next input to emerge 2 cycles after acceptance.
- sat_count limit: with CNT_W=2, feed 5 clipping samples. Expect sat_count to stop at 3.
